// File: rtl/wbs_pwm_capture_if.sv
// Wishbone B4 pipelined slave bus bundle for the PWM capture block.
// Write data is carried for bus completeness; the capture block ignores it.
interface wbs_pwm_capture_if;
  logic       wbs_stb_i;
  logic       wbs_we_i;
  logic [2:0] wbs_adr_i;
  logic [7:0] wbs_dat_i;
  logic [7:0] wbs_dat_o;
  logic       wbs_ack_o;

  modport master (output wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_dat_o, wbs_ack_o);
  modport slave  (input  wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
                  output wbs_dat_o, wbs_ack_o);
endinterface

// File: rtl/wbs_pwm_capture.sv
// PWM input capture: measures period and high time (in clocks) of pwm_in and
// exposes them over a byte-wide Wishbone slave with a coherent shadow snapshot.
module wbs_pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic               wbs_clk_i,
  input  logic               wbs_rst_i,
  wbs_pwm_capture_if.slave   bus,
  input  logic               pwm_in
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_period_cnt, r_high_cnt;
  logic [CNT_W-1:0] r_period_reg, r_high_reg;
  logic             r_valid, r_stall, r_armed;
  logic [7:0]       r_sh_high_hi, r_sh_per_lo, r_sh_per_hi;
  logic             r_ack;
  logic [7:0]       r_dat;

  logic             w_rise, w_publish, w_stall_hit;
  logic             w_rd, w_rd0, w_rd4;
  logic [23:0]      w_high_x, w_per_x;
  logic [7:0]       w_rd_mux;
  logic             w_unused_bits;

  assign w_rise      = r_s2 & ~r_s3;
  assign w_publish   = w_rise & r_armed & ~r_stall;
  assign w_stall_hit = ~w_rise & ~r_stall & (r_period_cnt == MAX);

  assign w_rd  = bus.wbs_stb_i & ~bus.wbs_we_i;
  assign w_rd0 = w_rd & (bus.wbs_adr_i == 3'd0);
  assign w_rd4 = w_rd & (bus.wbs_adr_i == 3'd4);

  // Results are zero-extended so the 16-bit byte map holds for any CNT_W.
  assign w_high_x      = 24'(r_high_reg);
  assign w_per_x       = 24'(r_period_reg);
  assign w_unused_bits = ^{bus.wbs_dat_i, w_high_x[23:16], w_per_x[23:16]};

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_period_reg <= '0;
      r_high_reg   <= '0;
      r_armed      <= 1'b0;
      r_stall      <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      if (w_rise) begin
        // First rise after reset or stall only arms; the old count is partial.
        if (w_publish) begin
          r_period_reg <= r_period_cnt;
          r_high_reg   <= r_high_cnt;
        end
        r_period_cnt <= CNT_W'(1);
        r_high_cnt   <= CNT_W'(1);
        r_armed      <= 1'b1;
        r_stall      <= 1'b0;
      end else begin
        if (r_period_cnt != MAX) r_period_cnt <= r_period_cnt + 1'b1;
        if (r_s2 && (r_high_cnt != MAX)) r_high_cnt <= r_high_cnt + 1'b1;
        if (w_stall_hit) begin
          r_stall      <= 1'b1;
          r_armed      <= 1'b0;
          r_period_reg <= MAX;
          r_high_reg   <= r_s2 ? MAX : '0;
        end
      end
      // A new result beats a same-cycle status read clearing valid.
      if (w_publish || w_stall_hit) r_valid <= 1'b1;
      else if (w_rd4)               r_valid <= 1'b0;
    end
  end

  always_comb begin
    w_rd_mux = 8'h00;
    case (bus.wbs_adr_i)
      3'd0:    w_rd_mux = w_high_x[7:0];
      3'd1:    w_rd_mux = r_sh_high_hi;
      3'd2:    w_rd_mux = r_sh_per_lo;
      3'd3:    w_rd_mux = r_sh_per_hi;
      3'd4:    w_rd_mux = {5'b0, r_s2, r_stall, r_valid};
      default: w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      r_ack        <= 1'b0;
      r_dat        <= 8'h00;
      r_sh_high_hi <= 8'h00;
      r_sh_per_lo  <= 8'h00;
      r_sh_per_hi  <= 8'h00;
    end else begin
      r_ack <= bus.wbs_stb_i;
      r_dat <= w_rd ? w_rd_mux : 8'h00;
      // Snapshot pre-update values so bytes 1..3 match the byte 0 just read.
      if (w_rd0) begin
        r_sh_high_hi <= w_high_x[15:8];
        r_sh_per_lo  <= w_per_x[7:0];
        r_sh_per_hi  <= w_per_x[15:8];
      end
    end
  end

  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_dat_o = r_dat;
endmodule

// File: tb/tb_wbs_pwm_capture.sv
// Bench for wbs_pwm_capture: timestamp-based reference model checked every
// cycle, plus literal expectations for directed PWM scenarios.
module tb_wbs_pwm_capture;
  localparam int CW  = 12;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_in = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  wbs_pwm_capture_if bus();

  wbs_pwm_capture #(.CNT_W(CW)) dut (
    .wbs_clk_i (clk),
    .wbs_rst_i (rst_n),
    .bus       (bus),
    .pwm_in    (pwm_in)
  );

  always #5 clk = ~clk;

  // PWM source: mode 0 periodic (P, H), mode 1 static level lvl.
  int   P = 10, H = 3, mode = 1, pmode = 1, ph = 0;
  logic lvl = 1'b0;
  always @(posedge clk) begin
    #2;
    if (mode == 0) begin
      if (pmode != 0) ph = 0;
      pwm_in = (ph < H);
      ph = (ph >= P - 1) ? 0 : ph + 1;
    end else begin
      pwm_in = lvl;
    end
    pmode = mode;
  end

  // Reference model: measurements from timestamps of synchronized edges.
  int   cyc = 0, rise_t = 0, fall_t = 0;
  bit   fell, s1, s2, s3, armed, stall, valid, m_ack;
  int   per, hig, sh_high, sh_per;
  logic [7:0] m_dat = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    int age;
    bit rise;
    logic [7:0] d;
    if (!rst_n) begin
      s1 = 0; s2 = 0; s3 = 0; armed = 0; stall = 0; valid = 0;
      per = 0; hig = 0; sh_high = 0; sh_per = 0;
      m_ack = 0; m_dat = 8'h00; rise_t = cyc; fell = 0;
    end else begin
      age = cyc - rise_t;
      if (age > MAX) age = MAX;
      rise = s2 && !s3;
      d = 8'h00;
      if (bus.wbs_stb_i && !bus.wbs_we_i)
        case (bus.wbs_adr_i)
          3'd0: d = hig[7:0];
          3'd1: d = sh_high[15:8];
          3'd2: d = sh_per[7:0];
          3'd3: d = sh_per[15:8];
          3'd4: d = {5'b0, s2, stall, valid};
          default: d = 8'h00;
        endcase
      m_ack = bus.wbs_stb_i;
      m_dat = d;
      if (bus.wbs_stb_i && !bus.wbs_we_i && bus.wbs_adr_i == 3'd0) begin
        sh_high = hig;
        sh_per  = per;
      end
      if (bus.wbs_stb_i && !bus.wbs_we_i && bus.wbs_adr_i == 3'd4) valid = 0;
      if (rise) begin
        if (armed && !stall) begin
          per = age;
          hig = fell ? fall_t - rise_t : age;
          if (hig > MAX) hig = MAX;
          valid = 1;
        end
        rise_t = cyc; fell = 0; armed = 1; stall = 0;
      end else if (!stall && age == MAX) begin
        stall = 1; armed = 0; per = MAX; hig = s2 ? MAX : 0; valid = 1;
      end
      if (!rise && !s2 && s3 && !fell) begin
        fall_t = cyc;
        fell = 1;
      end
      s3 = s2; s2 = s1; s1 = pwm_in;
      cyc++;
    end
  end

  always @(negedge clk) begin
    n_tests++;
    if (bus.wbs_ack_o !== m_ack) begin
      n_fail++;
      $display("FAIL ack @%0t: got %b want %b", $time, bus.wbs_ack_o, m_ack);
    end
    if (m_ack) begin
      n_tests++;
      if (bus.wbs_dat_o !== m_dat) begin
        n_fail++;
        $display("FAIL dat @%0t: got 0x%02h want 0x%02h", $time, bus.wbs_dat_o, m_dat);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = a;
    @(negedge clk);
    bus.wbs_stb_i = 1'b0;
    d = bus.wbs_dat_o;
  endtask

  logic [7:0] d;
  int acks;
  logic [3:0]      v_we;
  logic [3:0][2:0] v_adr;

  initial begin
    bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_ack", int'(bus.wbs_ack_o), 0);
    chk("reset_dat", int'(bus.wbs_dat_o), 0);
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) begin rd(3'(a), d); chk($sformatf("reset_reg%0d", a), d, 0); end

    // Period 10, high 3
    P = 10; H = 3; mode = 0;
    repeat (60) @(negedge clk);
    mode = 1; lvl = 0;
    repeat (10) @(negedge clk);
    rd(0, d); chk("t1_high_lo", d, 8'h03);
    rd(1, d); chk("t1_high_hi", d, 8'h00);
    rd(2, d); chk("t1_per_lo", d, 8'h0A);
    rd(3, d); chk("t1_per_hi", d, 8'h00);
    rd(4, d); chk("t1_status", d, 8'h01);
    rd(4, d); chk("t1_status2", d, 8'h00);

    // Coherent shadow across a waveform change
    P = 1000; H = 750; mode = 0;
    repeat (3200) @(negedge clk);
    rd(0, d); chk("t2_high_lo", d, 8'hEE);
    P = 400; H = 100;
    repeat (2500) @(negedge clk);
    rd(1, d); chk("t2_sh_high_hi", d, 8'h02);
    rd(2, d); chk("t2_sh_per_lo", d, 8'hE8);
    rd(3, d); chk("t2_sh_per_hi", d, 8'h03);
    rd(0, d); chk("t2_new_high_lo", d, 8'h64);
    rd(1, d); chk("t2_new_high_hi", d, 8'h00);
    rd(2, d); chk("t2_new_per_lo", d, 8'h90);
    rd(3, d); chk("t2_new_per_hi", d, 8'h01);

    // Held low -> stall; then two rises 20 apart
    mode = 1; lvl = 0;
    repeat (MAX + 200) @(negedge clk);
    rd(0, d); chk("t3_high_lo", d, 8'h00);
    rd(1, d); chk("t3_high_hi", d, 8'h00);
    rd(2, d); chk("t3_per_lo", d, 8'hFF);
    rd(3, d); chk("t3_per_hi", d, MAX >> 8);
    rd(4, d); chk("t3_status", d, 8'h03);
    lvl = 1;
    repeat (5) @(negedge clk);
    lvl = 0;
    rd(4, d); chk("t3_stall_cleared", int'(d[1]), 0);
    repeat (13) @(negedge clk);
    lvl = 1;
    repeat (5) @(negedge clk);
    lvl = 0;
    repeat (10) @(negedge clk);
    rd(0, d); chk("t3_rearm_high", d, 8'h05);
    rd(2, d); chk("t3_rearm_per_lo", d, 8'h14);
    rd(3, d); chk("t3_rearm_per_hi", d, 8'h00);
    rd(4, d); chk("t3_rearm_status", d, 8'h01);

    // Held high -> stall with high saturated
    lvl = 1;
    repeat (MAX + 200) @(negedge clk);
    rd(0, d); chk("t4_high_lo", d, 8'hFF);
    rd(1, d); chk("t4_high_hi", d, MAX >> 8);
    rd(2, d); chk("t4_per_lo", d, 8'hFF);
    rd(3, d); chk("t4_per_hi", d, MAX >> 8);
    rd(4, d); chk("t4_status", d, 8'h07);

    // Back-to-back mixed strobes
    lvl = 0;
    repeat (5) @(negedge clk);
    v_we  = 4'b0101;
    v_adr = {3'd6, 3'd4, 3'd2, 3'd0};
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0 && bus.wbs_ack_o === 1'b1) acks++;
      bus.wbs_stb_i = 1; bus.wbs_we_i = v_we[i]; bus.wbs_adr_i = v_adr[i];
      bus.wbs_dat_i = 8'hA5;
    end
    @(negedge clk);
    if (bus.wbs_ack_o === 1'b1) acks++;
    bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    chk("t5_b2b_acks", acks, 4);
    @(negedge clk);
    chk("t5_idle_ack", int'(bus.wbs_ack_o), 0);
    for (int a = 5; a < 8; a++) begin rd(3'(a), d); chk($sformatf("t5_reg%0d", a), d, 0); end
    rd(2, d); chk("t5_per_lo_kept", d, 8'hFF);
    rd(4, d); chk("t5_status", d, 8'h02);

    // Asynchronous reset during an active strobe
    P = 10; H = 3; mode = 0;
    repeat (100) @(negedge clk);
    @(negedge clk);
    bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 0;
    @(posedge clk);
    #1 chk("t6_ack_before_rst", int'(bus.wbs_ack_o), 1);
    #2 rst_n = 1'b0; mode = 1; lvl = 0;
    #1 chk("t6_ack_in_rst", int'(bus.wbs_ack_o), 0);
    chk("t6_dat_in_rst", int'(bus.wbs_dat_o), 0);
    @(negedge clk);
    bus.wbs_stb_i = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) begin rd(3'(a), d); chk($sformatf("t6_reg%0d", a), d, 0); end
    mode = 0;
    repeat (6) @(negedge clk);
    rd(4, d); chk("t6_first_rise_no_pub", int'(d[0]), 0);
    repeat (30) @(negedge clk);
    rd(4, d); chk("t6_second_rise_pub", int'(d[0]), 1);
    rd(0, d); chk("t6_high_lo", d, 8'h03);
    rd(2, d); chk("t6_per_lo", d, 8'h0A);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
